// File: rtl/pipe_ctrl_pkg.sv
// Constants and state type shared by the pipeline control blocks (hazard_detect, stall_ctrl).
package pipe_ctrl_pkg;

    localparam logic [1:0] NOOP_NONE    = 2'b00;
    localparam logic [1:0] NOOP_ONE     = 2'b01;
    localparam logic [1:0] NOOP_TWO     = 2'b10;
    localparam logic [1:0] NOOP_ILLEGAL = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } stallState_e;

    // The illegal code is handled as a two-cycle request so the pipeline stays safe.
    function automatic logic [1:0] reqCycles(input logic [1:0] noOp);
        logic [1:0] cycles;
        case (noOp)
            NOOP_NONE: cycles = 2'd0;
            NOOP_ONE:  cycles = 2'd1;
            default:   cycles = 2'd2;
        endcase
        return cycles;
    endfunction

    function automatic logic [1:0] satDec(input logic [1:0] value);
        return (value == 2'd0) ? 2'd0 : value - 2'd1;
    endfunction

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall sequencer: turns hazard_detect NoOp codes into PC, IF/ID and ID/EX write controls.
module stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       NoOp,
    input  logic             BranchTaken,
    input  logic             MemHold,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXBubble,
    output logic             StallActive,
    output logic [CNT_W-1:0] StallCycles,
    output logic             IllegalReq
);

    stallState_e state, stateNext;
    logic [1:0]  rem, remNext;
    logic [1:0]  req;
    logic        stall;
    logic        illegalSeen;

    assign req   = reqCycles(NoOp);
    assign stall = (state == HOLD) || (req != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            rem         <= 2'd0;
            illegalSeen <= 1'b0;
        end else begin
            state <= stateNext;
            rem   <= remNext;
            if (NoOp == NOOP_ILLEGAL) begin
                illegalSeen <= 1'b1;
            end
        end
    end

    // MemHold freezes everything; otherwise a stall bubbles ID/EX and overrides any branch flush.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXWrite   = 1'b1;
        IDEXBubble  = 1'b0;
        StallActive = 1'b0;
        stateNext   = state;
        remNext     = rem;
        if (!reset) begin
            if (MemHold) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXWrite = 1'b0;
            end else begin
                if (stall) begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEXBubble  = 1'b1;
                    StallActive = 1'b1;
                end else begin
                    IFIDFlush = BranchTaken;
                end
                // Longest outstanding demand wins, so requests never shorten or stack.
                remNext   = (satDec(rem) > satDec(req)) ? satDec(rem) : satDec(req);
                stateNext = (remNext != 2'd0) ? HOLD : RUN;
            end
        end
    end

    sat_counter #(.W(CNT_W)) uStallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (StallActive),
        .count (StallCycles)
    );

    assign IllegalReq = illegalSeen;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl with a 4-bit counter so saturation is reachable.
module tb_stall_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       NoOp;
    logic             BranchTaken;
    logic             MemHold;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXWrite;
    logic             IDEXBubble;
    logic             StallActive;
    logic [CNT_W-1:0] StallCycles;
    logic             IllegalReq;

    int checkCount = 0;
    int errorCount = 0;

    stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .NoOp        (NoOp),
        .BranchTaken (BranchTaken),
        .MemHold     (MemHold),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .IFIDFlush   (IFIDFlush),
        .IDEXWrite   (IDEXWrite),
        .IDEXBubble  (IDEXBubble),
        .StallActive (StallActive),
        .StallCycles (StallCycles),
        .IllegalReq  (IllegalReq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 ns after the rising edge and settle before outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic [1:0] noOp, input logic br, input logic mh);
        reset       = rst;
        NoOp        = noOp;
        BranchTaken = br;
        MemHold     = mh;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOuts(input string tag, input logic pc, input logic ifid, input logic flush,
                              input logic idex, input logic bubble, input logic active);
        checkOutput({tag, ".PCWrite"},     {31'd0, PCWrite},     {31'd0, pc});
        checkOutput({tag, ".IFIDWrite"},   {31'd0, IFIDWrite},   {31'd0, ifid});
        checkOutput({tag, ".IFIDFlush"},   {31'd0, IFIDFlush},   {31'd0, flush});
        checkOutput({tag, ".IDEXWrite"},   {31'd0, IDEXWrite},   {31'd0, idex});
        checkOutput({tag, ".IDEXBubble"},  {31'd0, IDEXBubble},  {31'd0, bubble});
        checkOutput({tag, ".StallActive"}, {31'd0, StallActive}, {31'd0, active});
    endtask

    task automatic expectStall(input string tag);
        expectOuts(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic expectRun(input string tag, input logic flush);
        expectOuts(tag, 1'b1, 1'b1, flush, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic checkCount4(input string tag, input int expected);
        checkOutput(tag, {28'd0, StallCycles}, expected[31:0]);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);

        // Reset holds RUN outputs even with a two-cycle request present.
        expectRun("rst0", 1'b0);
        clockEdge();
        expectRun("rst1", 1'b0);
        clockEdge();
        checkCount4("rst.StallCycles", 0);
        checkOutput("rst.IllegalReq", {31'd0, IllegalReq}, 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectRun("postRst", 1'b0);
        clockEdge();

        // Single-cycle stall.
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
        expectStall("one.s0");
        clockEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectRun("one.run", 1'b0);
        checkCount4("one.count", 1);
        clockEdge();

        // Two-cycle stall, then one re-requested during HOLD giving three stall cycles.
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        expectStall("two.s0");
        clockEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectStall("two.s1");
        clockEdge();
        expectRun("two.run", 1'b0);
        checkCount4("two.count", 3);
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        expectStall("three.s0");
        clockEdge();
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        expectStall("three.s1");
        clockEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectStall("three.s2");
        clockEdge();
        expectRun("three.run", 1'b0);
        checkCount4("three.count", 6);

        // Stall beats branch flush; flush appears once the stall ends.
        applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
        expectStall("br.stall");
        clockEdge();
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
        expectRun("br.flush", 1'b1);
        clockEdge();

        // MemHold freeze in the middle of a two-cycle stall.
        doReset();
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        expectStall("mh.s0");
        clockEdge();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
            expectOuts($sformatf("mh.frz%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            clockEdge();
            checkCount4($sformatf("mh.count%0d", i), 1);
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectStall("mh.s1");
        clockEdge();
        expectRun("mh.run", 1'b0);
        checkCount4("mh.countEnd", 2);

        // A request arriving under MemHold is dropped.
        applyStimulus(1'b0, 2'b01, 1'b0, 1'b1);
        expectOuts("mhDrop.frz", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectRun("mhDrop.run", 1'b0);
        checkCount4("mhDrop.count", 2);

        // Reset during HOLD leaves no residual bubble.
        applyStimulus(1'b0, 2'b10, 1'b0, 1'b0);
        clockEdge();
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        expectRun("rstHold.inRst", 1'b0);
        clockEdge();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectRun("rstHold.after", 1'b0);
        checkCount4("rstHold.count", 0);

        // Counter saturation at 15 with a 4-bit counter.
        doReset();
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
            clockEdge();
            checkCount4($sformatf("sat.c%0d", i), (i > 15) ? 15 : i);
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        clockEdge();
        checkCount4("sat.hold", 15);

        // Illegal code: sticky flag plus a two-cycle stall.
        applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
        expectStall("ill.s0");
        checkOutput("ill.before", {31'd0, IllegalReq}, 32'd0);
        clockEdge();
        checkOutput("ill.set", {31'd0, IllegalReq}, 32'd1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
        expectStall("ill.s1");
        clockEdge();
        expectRun("ill.run", 1'b0);
        clockEdge();
        checkOutput("ill.sticky", {31'd0, IllegalReq}, 32'd1);
        doReset();
        checkOutput("ill.cleared", {31'd0, IllegalReq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
